// File: rtl/writeback_stage_pkg.sv
// -----------------------------------------------------------------------------
// writeback_stage_pkg
// Shared definitions for the writeback stage: register/data widths, the
// result-source encodings carried on inSel, the load funct3 codes understood
// by the load formatter, and the writeback state type.
// -----------------------------------------------------------------------------
package writeback_stage_pkg;

  localparam int REG_W  = 5;
  localparam int DATA_W = 32;

  // Result source selection presented by the memory stage
  localparam logic [1:0] SEL_ALU  = 2'd0;
  localparam logic [1:0] SEL_LOAD = 2'd1;
  localparam logic [1:0] SEL_PC4  = 2'd2;
  localparam logic [1:0] SEL_NONE = 2'd3;

  // Load width/sign codes (RISC-V funct3)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    ST_IDLE,
    ST_WRITE
  } wbState_e;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// -----------------------------------------------------------------------------
// load_extend
// Purely combinational load formatter. Picks the addressed byte or halfword
// out of the aligned memory word and sign- or zero-extends it to 32 bits.
// Ports:
//   i_loadData   - raw aligned memory word
//   i_loadFunct3 - load type (LB/LH/LW/LBU/LHU); anything else yields 0
//   i_loadOffset - byte address bits [1:0]
//   o_result     - formatted 32-bit register value
// -----------------------------------------------------------------------------
module load_extend
  import writeback_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_loadData,
  input  logic [2:0]        i_loadFunct3,
  input  logic [1:0]        i_loadOffset,
  output logic [DATA_W-1:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane selection. The halfword only looks at offset bit 1, so an odd
  // halfword offset silently reads the enclosing aligned halfword; alignment
  // faults are the job of an earlier stage.
  always_comb begin
    w_byte = 8'h00;
    case (i_loadOffset)
      2'd0: w_byte = i_loadData[7:0];
      2'd1: w_byte = i_loadData[15:8];
      2'd2: w_byte = i_loadData[23:16];
      2'd3: w_byte = i_loadData[31:24];
      default: w_byte = 8'h00;
    endcase
    w_half = i_loadOffset[1] ? i_loadData[31:16] : i_loadData[15:0];
  end

  // Extension according to the load type; unsupported codes write zero so
  // the register file never sees stale or undefined data.
  always_comb begin
    o_result = '0;
    case (i_loadFunct3)
      F3_LB:   o_result = {{24{w_byte[7]}}, w_byte};
      F3_LH:   o_result = {{16{w_half[15]}}, w_half};
      F3_LW:   o_result = i_loadData;
      F3_LBU:  o_result = {24'h000000, w_byte};
      F3_LHU:  o_result = {16'h0000, w_half};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// -----------------------------------------------------------------------------
// writeback_stage
// Final pipeline stage. Accepts one completed instruction per inValid/inReady
// handshake, formats the result and holds a register file write until the
// register file acknowledges it with writeBackComplete. A write that is not
// acknowledged within TIMEOUT_CYCLES cycles is dropped and flags timeoutErr.
// Ports:
//   clock, reset        - rising-edge clock, async active-high reset
//   inValid / inReady   - handshake with the memory stage
//   inRd, inSel         - destination register and result source
//   aluResult, pcPlus4, loadData, loadFunct3, loadOffset - result operands
//   writeEnable/Addr/Data - register file write port (held until complete)
//   writeBackComplete   - register file acknowledge
//   fwdValid            - writeAddr/writeData usable for forwarding
//   retiredCount        - retired instruction counter (wraps)
//   timeoutErr          - sticky timeout flag
// -----------------------------------------------------------------------------
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              inValid,
  output logic              inReady,
  input  logic [REG_W-1:0]  inRd,
  input  logic [1:0]        inSel,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] pcPlus4,
  input  logic [DATA_W-1:0] loadData,
  input  logic [2:0]        loadFunct3,
  input  logic [1:0]        loadOffset,
  output logic              writeEnable,
  output logic [REG_W-1:0]  writeAddr,
  output logic [DATA_W-1:0] writeData,
  input  logic              writeBackComplete,
  output logic              fwdValid,
  output logic [CNT_W-1:0]  retiredCount,
  output logic              timeoutErr
);

  localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  wbState_e          r_state;
  logic [TO_W-1:0]   r_toCnt;

  logic              w_accept;
  logic              w_noWrite;
  logic              w_complete;
  logic              w_timeout;
  logic [DATA_W-1:0] w_loadResult;
  logic [DATA_W-1:0] w_result;
  logic [CNT_W-1:0]  w_retireInc;

  load_extend u_loadExtend (
    .i_loadData   (loadData),
    .i_loadFunct3 (loadFunct3),
    .i_loadOffset (loadOffset),
    .o_result     (w_loadResult)
  );

  // Ready is combinational on the acknowledge so that a new write can be
  // loaded on the very edge the previous one completes, keeping writeEnable
  // high continuously across back-to-back writes.
  assign inReady    = (r_state == ST_IDLE) || writeBackComplete;
  assign w_accept   = inValid && inReady;
  assign w_noWrite  = (inSel == SEL_NONE) || (inRd == '0);
  assign w_complete = (r_state == ST_WRITE) && writeBackComplete;
  assign w_timeout  = (r_state == ST_WRITE) && !writeBackComplete && (r_toCnt == TO_LAST);

  // Up to two instructions can retire on one edge: the write that completes
  // and a no-write instruction accepted alongside it.
  assign w_retireInc = CNT_W'(w_complete) + CNT_W'(w_accept && w_noWrite);

  // Result source multiplexer; SEL_NONE never reaches the register file.
  always_comb begin
    w_result = '0;
    case (inSel)
      SEL_ALU:  w_result = aluResult;
      SEL_LOAD: w_result = w_loadResult;
      SEL_PC4:  w_result = pcPlus4;
      default:  w_result = '0;
    endcase
  end

  // Writeback FSM with registered write-port outputs. IDLE waits for an
  // instruction that actually writes; WRITE holds the port until the register
  // file acknowledges or the wait budget runs out. Reset drops any pending
  // write on the spot.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_toCnt      <= '0;
      writeEnable  <= 1'b0;
      writeAddr    <= '0;
      writeData    <= '0;
      fwdValid     <= 1'b0;
      retiredCount <= '0;
      timeoutErr   <= 1'b0;
    end else begin
      retiredCount <= retiredCount + w_retireInc;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && !w_noWrite) begin
            writeAddr   <= inRd;
            writeData   <= w_result;
            writeEnable <= 1'b1;
            fwdValid    <= 1'b1;
            r_toCnt     <= '0;
            r_state     <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (w_complete) begin
            r_toCnt <= '0;
            if (w_accept && !w_noWrite) begin
              writeAddr <= inRd;
              writeData <= w_result;
            end else begin
              writeEnable <= 1'b0;
              fwdValid    <= 1'b0;
              r_state     <= ST_IDLE;
            end
          end else if (w_timeout) begin
            writeEnable <= 1'b0;
            fwdValid    <= 1'b0;
            timeoutErr  <= 1'b1;
            r_toCnt     <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_toCnt <= r_toCnt + TO_W'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          writeEnable <= 1'b0;
          fwdValid    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// -----------------------------------------------------------------------------
// tb_writeback_stage
// Directed bench for writeback_stage with a transaction-level model of the
// stage (one pending write, a wait counter, a retire count) checked against
// the DUT on every falling edge, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_writeback_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        inValid = 1'b0;
  logic        inReady;
  logic [4:0]  inRd = '0;
  logic [1:0]  inSel = '0;
  logic [31:0] aluResult = '0;
  logic [31:0] pcPlus4 = '0;
  logic [31:0] loadData = '0;
  logic [2:0]  loadFunct3 = '0;
  logic [1:0]  loadOffset = '0;
  logic        writeEnable;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic        writeBackComplete = 1'b0;
  logic        fwdValid;
  logic [31:0] retiredCount;
  logic        timeoutErr;

  int nCompared = 0;
  int nMismatch = 0;

  // Model state: is a write pending, what it writes, how long it has waited
  bit          mPend = 1'b0;
  logic [4:0]  mAddr = '0;
  logic [31:0] mData = '0;
  int          mWaited = 0;
  logic [31:0] mRetired = '0;
  bit          mErr = 1'b0;
  bit          mAcc;

  // Load test table
  logic [2:0]  ldF3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
  logic [1:0]  ldOff [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
  logic [31:0] ldExp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01};
  string       ldName[5] = '{"LB", "LBU", "LH", "LHU", "LW"};

  writeback_stage #(
    .TIMEOUT_CYCLES (TO),
    .CNT_W          (32)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .inValid           (inValid),
    .inReady           (inReady),
    .inRd              (inRd),
    .inSel             (inSel),
    .aluResult         (aluResult),
    .pcPlus4           (pcPlus4),
    .loadData          (loadData),
    .loadFunct3        (loadFunct3),
    .loadOffset        (loadOffset),
    .writeEnable       (writeEnable),
    .writeAddr         (writeAddr),
    .writeData         (writeData),
    .writeBackComplete (writeBackComplete),
    .fwdValid          (fwdValid),
    .retiredCount      (retiredCount),
    .timeoutErr        (timeoutErr)
  );

  always #5 clock = ~clock;

  // One comparison: bumps the counters, reports a failure line on mismatch
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatch++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, let one rising edge consume them, and return
  // two time units after that edge
  task automatic applyStimulus(input logic v, input logic [4:0] rd, input logic [1:0] sel,
                               input logic [31:0] alu, input logic [31:0] pc4,
                               input logic [31:0] ld, input logic [2:0] f3,
                               input logic [1:0] off, input logic wbc);
    inValid = v;
    inRd = rd;
    inSel = sel;
    aluResult = alu;
    pcPlus4 = pc4;
    loadData = ld;
    loadFunct3 = f3;
    loadOffset = off;
    writeBackComplete = wbc;
    @(posedge clock);
    #2;
  endtask

  task automatic idleCycle(input logic wbc);
    applyStimulus(1'b0, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, 3'b000, 2'd0, wbc);
  endtask

  // Register value the instruction must produce, written from the load rules
  // with shifts and masks
  function automatic logic [31:0] formatResult(input logic [1:0] sel, input logic [31:0] alu,
                                               input logic [31:0] pc4, input logic [31:0] ld,
                                               input logic [2:0] f3, input logic [1:0] off);
    logic [31:0] b;
    logic [31:0] h;
    b = (ld >> (8 * int'(off))) & 32'hFF;
    h = (ld >> (off[1] ? 16 : 0)) & 32'hFFFF;
    case (sel)
      2'd0: return alu;
      2'd2: return pc4;
      2'd1: begin
        case (f3)
          3'b000: return (b >= 32'd128) ? (b | 32'hFFFFFF00) : b;
          3'b001: return (h >= 32'd32768) ? (h | 32'hFFFF0000) : h;
          3'b010: return ld;
          3'b100: return b;
          3'b101: return h;
          default: return 32'h0;
        endcase
      end
      default: return 32'h0;
    endcase
  endfunction

  // Transaction model, advanced on each rising edge or on reset
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        mPend = 1'b0;
        mAddr = '0;
        mData = '0;
        mWaited = 0;
        mRetired = '0;
        mErr = 1'b0;
      end else begin
        mAcc = inValid && (!mPend || writeBackComplete);
        if (mPend) begin
          mWaited++;
          if (writeBackComplete) begin
            mRetired++;
            mPend = 1'b0;
          end else if (mWaited >= TO) begin
            mErr = 1'b1;
            mPend = 1'b0;
          end
        end
        if (mAcc) begin
          if (inSel == 2'd3 || inRd == 5'd0) begin
            mRetired++;
          end else begin
            mPend = 1'b1;
            mAddr = inRd;
            mData = formatResult(inSel, aluResult, pcPlus4, loadData, loadFunct3, loadOffset);
            mWaited = 0;
          end
        end
      end
    end
  end

  // Every-cycle comparison of the DUT against the model on the falling edge
  initial begin
    forever begin
      @(negedge clock);
      checkOutput("cyc.writeEnable", {31'b0, writeEnable}, {31'b0, mPend});
      checkOutput("cyc.fwdValid", {31'b0, fwdValid}, {31'b0, mPend});
      checkOutput("cyc.inReady", {31'b0, inReady}, {31'b0, (!mPend || writeBackComplete)});
      checkOutput("cyc.retiredCount", retiredCount, mRetired);
      checkOutput("cyc.timeoutErr", {31'b0, timeoutErr}, {31'b0, mErr});
      if (mPend) begin
        checkOutput("cyc.writeAddr", {27'b0, writeAddr}, {27'b0, mAddr});
        checkOutput("cyc.writeData", writeData, mData);
      end
    end
  end

  // Directed scenario sequence
  initial begin
    #1 reset = 1'b1;
    #1;
    checkOutput("rst.writeEnable", {31'b0, writeEnable}, 32'd0);
    checkOutput("rst.inReady", {31'b0, inReady}, 32'd1);
    checkOutput("rst.retiredCount", retiredCount, 32'd0);
    checkOutput("rst.timeoutErr", {31'b0, timeoutErr}, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #2 reset = 1'b0;

    // Pin the model against hand-computed load formatting
    for (int i = 0; i < 5; i++)
      checkOutput({"model.", ldName[i]},
                  formatResult(2'd1, 32'h0, 32'h0, 32'h80FF7F01, ldF3[i], ldOff[i]), ldExp[i]);
    checkOutput("model.badF3", formatResult(2'd1, 32'h0, 32'h0, 32'h80FF7F01, 3'b111, 2'd0), 32'h0);

    // ALU write held three cycles, then acknowledged
    applyStimulus(1'b1, 5'd2, 2'd0, 32'hFFFFFFFF, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    checkOutput("alu.writeEnable", {31'b0, writeEnable}, 32'd1);
    checkOutput("alu.writeAddr", {27'b0, writeAddr}, 32'd2);
    checkOutput("alu.writeData", writeData, 32'hFFFFFFFF);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("alu.held", {31'b0, writeEnable}, 32'd1);
    idleCycle(1'b1);
    checkOutput("alu.dropped", {31'b0, writeEnable}, 32'd0);
    checkOutput("alu.retired", retiredCount, 32'd1);

    // Load extension cases
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 5'd7, 2'd1, 32'h0, 32'h0, 32'h80FF7F01, ldF3[i], ldOff[i], 1'b0);
      checkOutput({"load.", ldName[i]}, writeData, ldExp[i]);
      idleCycle(1'b1);
    end
    checkOutput("load.retired", retiredCount, 32'd6);

    // Instructions that retire without writing
    applyStimulus(1'b1, 5'd0, 2'd0, 32'h1234, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    checkOutput("x0.writeEnable", {31'b0, writeEnable}, 32'd0);
    checkOutput("x0.inReady", {31'b0, inReady}, 32'd1);
    applyStimulus(1'b1, 5'd5, 2'd3, 32'h1234, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    checkOutput("none.writeEnable", {31'b0, writeEnable}, 32'd0);
    checkOutput("none.retired", retiredCount, 32'd8);

    // Back-to-back writes replaced on the completing edge
    applyStimulus(1'b1, 5'd4, 2'd0, 32'h11, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    checkOutput("b2b.addr1", {27'b0, writeAddr}, 32'd4);
    checkOutput("b2b.data1", writeData, 32'h11);
    applyStimulus(1'b1, 5'd6, 2'd2, 32'h0, 32'h104, 32'h0, 3'b000, 2'd0, 1'b1);
    checkOutput("b2b.writeEnable", {31'b0, writeEnable}, 32'd1);
    checkOutput("b2b.addr2", {27'b0, writeAddr}, 32'd6);
    checkOutput("b2b.data2", writeData, 32'h104);
    checkOutput("b2b.retired1", retiredCount, 32'd9);
    idleCycle(1'b1);
    checkOutput("b2b.retired2", retiredCount, 32'd10);

    // Timeout after TO unacknowledged cycles
    applyStimulus(1'b1, 5'd9, 2'd0, 32'hDEAD, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    idleCycle(1'b0);
    checkOutput("to.stillHeld", {31'b0, writeEnable}, 32'd1);
    checkOutput("to.notYet", {31'b0, timeoutErr}, 32'd0);
    idleCycle(1'b0);
    checkOutput("to.writeEnable", {31'b0, writeEnable}, 32'd0);
    checkOutput("to.timeoutErr", {31'b0, timeoutErr}, 32'd1);
    checkOutput("to.retired", retiredCount, 32'd10);
    idleCycle(1'b1);
    checkOutput("to.sticky", {31'b0, timeoutErr}, 32'd1);
    applyStimulus(1'b1, 5'd3, 2'd0, 32'h55, 32'h0, 32'h0, 3'b000, 2'd0, 1'b0);
    checkOutput("to.nextAccepted", {31'b0, writeEnable}, 32'd1);
    checkOutput("to.nextAddr", {27'b0, writeAddr}, 32'd3);

    // Asynchronous reset while a write is pending
    #1 reset = 1'b1;
    #1;
    checkOutput("arst.writeEnable", {31'b0, writeEnable}, 32'd0);
    checkOutput("arst.writeAddr", {27'b0, writeAddr}, 32'd0);
    checkOutput("arst.writeData", writeData, 32'd0);
    checkOutput("arst.fwdValid", {31'b0, fwdValid}, 32'd0);
    checkOutput("arst.retired", retiredCount, 32'd0);
    checkOutput("arst.timeoutErr", {31'b0, timeoutErr}, 32'd0);
    checkOutput("arst.inReady", {31'b0, inReady}, 32'd1);
    #10 reset = 1'b0;
    idleCycle(1'b1);
    checkOutput("post.idleAck", retiredCount, 32'd0);
    idleCycle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
